// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: groups the instruction handshake, ALU drive/return,
// flag/status pulses and host register-write port of the ALU sequencer.
// The sequencer connects through the 'slave' modport; the surrounding
// datapath (fetch path, ALU, host) connects through 'master'.
interface alu_sequencer_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] alu_r1;
    logic [15:0] alu_r2;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_rout;
    logic [7:0]  alu_flags;
    logic [7:0]  flags;
    logic        done;
    logic        err;
    logic        host_we;
    logic [3:0]  host_addr;
    logic [15:0] host_data;
    logic        load_err;

    modport slave (
        input  instr, instr_valid, alu_rout, alu_flags,
               host_we, host_addr, host_data,
        output instr_ready, alu_r1, alu_r2, alu_opcode,
               flags, done, err, load_err
    );

    modport master (
        output instr, instr_valid, alu_rout, alu_flags,
               host_we, host_addr, host_data,
        input  instr_ready, alu_r1, alu_r2, alu_opcode,
               flags, done, err, load_err
    );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state initiator for the 16-bit combinational ALU.
// Accepts an instruction, reads two operands from a 16x16 register file,
// drives the ALU, captures result/flags and writes back by opcode class.
// Optional feature macro: ALU_SEQ_DBG_EN adds a registered debug read port
// (dbg_addr/dbg_data); without it those ports do not exist.
module alu_sequencer (
    input  logic             clk,
    input  logic             reset,
`ifdef ALU_SEQ_DBG_EN
    input  logic [3:0]       dbg_addr,
    output logic [15:0]      dbg_data,
`endif
    alu_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

    localparam logic [1:0] C_NONE = 2'd0; // no write, no flags, err
    localparam logic [1:0] C_WR   = 2'd1; // write R[A] only
    localparam logic [1:0] C_WRF  = 2'd2; // write R[A] and load flags
    localparam logic [1:0] C_FL   = 2'd3; // load flags only

    // Map an opcode onto its writeback class.
    function automatic logic [1:0] op_class(input logic [7:0] op);
        case (op)
            8'h01, 8'h02, 8'h03, 8'h04, 8'h06,
            8'h07, 8'h08, 8'h0C, 8'h0F, 8'h84: op_class = C_WR;
            8'h05, 8'h09:                      op_class = C_WRF;
            8'h0B:                             op_class = C_FL;
            default:                           op_class = C_NONE;
        endcase
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_instr;
    logic        r_instr_ready;
    logic [15:0] r_alu_r1;
    logic [15:0] r_alu_r2;
    logic [7:0]  r_alu_opcode;
    logic [15:0] r_res;
    logic [7:0]  r_aflags;
    logic [7:0]  r_flags;
    logic        r_done;
    logic        r_err;
    logic        r_load_err;
    logic [15:0] r_regs [0:15];

    logic        w_accept;
    logic        w_host_ok;
    logic        w_host_rej;
    logic [1:0]  w_class;
    logic        w_wb_reg;
    logic        w_wb_flags;

    // An instruction takes priority over a host write in IDLE.
    assign w_accept   = (r_state == S_IDLE) && bus.instr_valid && r_instr_ready;
    assign w_host_ok  = (r_state == S_IDLE) && !bus.instr_valid && bus.host_we;
    assign w_host_rej = bus.host_we && !w_host_ok;
    assign w_class    = op_class(r_instr[15:8]);
    assign w_wb_reg   = (r_state == S_WRITE) && ((w_class == C_WR) || (w_class == C_WRF));
    assign w_wb_flags = (r_state == S_WRITE) && ((w_class == C_WRF) || (w_class == C_FL));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state: fixed READ -> EXEC -> WRITE walk after an accept.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_READ;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Instruction latch and registered ready (high exactly while IDLE).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr       <= 16'd0;
            r_instr_ready <= 1'b1;
        end else begin
            if (w_accept) begin
                r_instr <= bus.instr;
            end
            r_instr_ready <= (w_next == S_IDLE);
        end
    end

    // ALU operand/opcode drive: loaded in READ, held until the next READ.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_r1     <= 16'd0;
            r_alu_r2     <= 16'd0;
            r_alu_opcode <= 8'd0;
        end else if (r_state == S_READ) begin
            r_alu_r1     <= r_regs[r_instr[7:4]];
            r_alu_r2     <= r_regs[r_instr[3:0]];
            r_alu_opcode <= r_instr[15:8];
        end
    end

    // Capture the settled ALU result and flags during EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res    <= 16'd0;
            r_aflags <= 8'd0;
        end else if (r_state == S_EXEC) begin
            r_res    <= bus.alu_rout;
            r_aflags <= bus.alu_flags;
        end
    end

    // Register file and architectural flags: host writes in IDLE, writeback in WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 16'd0;
            end
            r_flags <= 8'd0;
        end else begin
            if (w_host_ok) begin
                r_regs[bus.host_addr] <= bus.host_data;
            end else if (w_wb_reg) begin
                r_regs[r_instr[7:4]] <= r_res;
            end
            if (w_wb_flags) begin
                r_flags <= r_aflags;
            end
        end
    end

    // One-cycle status pulses: retire, unsupported opcode, rejected host write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_done     <= (r_state == S_WRITE);
            r_err      <= (r_state == S_WRITE) && (w_class == C_NONE);
            r_load_err <= w_host_rej;
        end
    end

`ifdef ALU_SEQ_DBG_EN
    logic [15:0] r_dbg_data;

    // Debug read port: one-cycle registered view of R[dbg_addr].
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbg_data <= 16'd0;
        end else begin
            r_dbg_data <= r_regs[dbg_addr];
        end
    end

    assign dbg_data = r_dbg_data;
`endif

    assign bus.instr_ready = r_instr_ready;
    assign bus.alu_r1      = r_alu_r1;
    assign bus.alu_r2      = r_alu_r2;
    assign bus.alu_opcode  = r_alu_opcode;
    assign bus.flags       = r_flags;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.load_err    = r_load_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed plus randomized test of alu_sequencer against a
// behavioural model (register array + flag byte) and a behavioural ALU.
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_sequencer_if bus();

`ifdef ALU_SEQ_DBG_EN
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
`endif

    alu_sequencer dut (
        .clk      (clk),
        .reset    (reset),
`ifdef ALU_SEQ_DBG_EN
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
`endif
        .bus      (bus)
    );

    // Behavioural ALU: returns {flags, result}. Flags N=7 Z=6 F=5 L=2 C=0.
    function automatic logic [23:0] alu_model(input logic [7:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] r;
        logic c, f, l;
        c = 1'b0; f = 1'b0; l = 1'b0; w = 17'd0;
        case (op)
            8'h01: r = a & b;
            8'h02: r = a | b;
            8'h03: r = a ^ b;
            8'h04: r = ~a;
            8'h05: begin
                w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                f = (a[15] == b[15]) && (r[15] != a[15]);
            end
            8'h06: r = a << 1;
            8'h07: r = a >> 1;
            8'h08: r = b;
            8'h09, 8'h0B: begin
                w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16];
                f = (a[15] != b[15]) && (r[15] != a[15]);
                l = ($signed(a) < $signed(b));
            end
            8'h0C: r = a + 16'd1;
            8'h0F: r = a - 16'd1;
            8'h84: r = {a[7:0], a[15:8]};
            default: r = a ^ b ^ 16'hA5A5;
        endcase
        return {r[15], (r == 16'd0), f, 1'b0, 1'b0, l, 1'b0, c, r};
    endfunction

    assign {bus.alu_flags, bus.alu_rout} = alu_model(bus.alu_opcode, bus.alu_r1, bus.alu_r2);

    int checks = 0;
    int failures = 0;
    logic [15:0] m_regs [16];
    logic [7:0]  m_flags;
    logic [7:0]  op_list [14] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                  8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84, 8'hEE};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 16'd0;
        m_flags = 8'd0;
    endtask

    task automatic host_write(input logic [3:0] addr, input logic [15:0] data);
        bus.host_we = 1'b1; bus.host_addr = addr; bus.host_data = data;
        tick();
        bus.host_we = 1'b0;
        m_regs[addr] = data;
        chk("hw_load_err", bus.load_err, 32'd0);
        chk("hw_ready", bus.instr_ready, 32'd1);
    endtask

    // Issue one instruction; rej (1..4) puts a host write on the edge of that
    // cycle index (1 = accept edge), which must be rejected.
    task automatic do_instr(input logic [15:0] ins, input int rej);
        logic [7:0]  op;
        logic [3:0]  a, b;
        logic [15:0] va, vb;
        logic [23:0] res;
        logic        wr_reg, wr_flg, bad;
        op = ins[15:8]; a = ins[7:4]; b = ins[3:0];
        va = m_regs[a]; vb = m_regs[b];
        res = alu_model(op, va, vb);
        wr_reg = op inside {8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07, 8'h08,
                            8'h0C, 8'h0F, 8'h84, 8'h05, 8'h09};
        wr_flg = op inside {8'h05, 8'h09, 8'h0B};
        bad    = !(wr_reg || wr_flg);
        if (wr_reg) m_regs[a] = res[15:0];
        if (wr_flg) m_flags = res[23:16];
        chk("ready_pre", bus.instr_ready, 32'd1);
        bus.instr = ins; bus.instr_valid = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            if (t == rej) begin
                bus.host_we = 1'b1; bus.host_addr = a; bus.host_data = ~va;
            end
            tick();
            bus.instr_valid = 1'b0; bus.host_we = 1'b0;
            if (rej != 0) chk("load_err", bus.load_err, {31'd0, (t == rej)});
            if (t < 4) begin
                chk("done_early", bus.done, 32'd0);
                chk("ready_busy", bus.instr_ready, 32'd0);
            end
            if (t == 2) begin
                chk("alu_r1", bus.alu_r1, {16'd0, va});
                chk("alu_r2", bus.alu_r2, {16'd0, vb});
                chk("alu_opcode", bus.alu_opcode, {24'd0, op});
            end
            if (t == 4) begin
                chk("done", bus.done, 32'd1);
                chk("err", bus.err, {31'd0, bad});
                chk("flags", bus.flags, {24'd0, m_flags});
                chk("ready_back", bus.instr_ready, 32'd1);
            end
        end
    endtask

    // Read back R[r] through the operand path using an unsupported opcode.
    task automatic probe(input logic [3:0] r);
        do_instr({8'h00, r, r}, 0);
    endtask

    initial begin
        logic [15:0] rv;
        bus.instr = 16'd0; bus.instr_valid = 1'b0;
        bus.host_we = 1'b0; bus.host_addr = 4'd0; bus.host_data = 16'd0;
`ifdef ALU_SEQ_DBG_EN
        dbg_addr = 4'd1;
`endif
        reset = 1'b1;
        model_reset();
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready", bus.instr_ready, 32'd1);
        chk("rst_done", bus.done, 32'd0);
        chk("rst_err", bus.err, 32'd0);
        chk("rst_flags", bus.flags, 32'd0);
        chk("rst_r1", bus.alu_r1, 32'd0);
        chk("rst_op", bus.alu_opcode, 32'd0);
        chk("rst_load_err", bus.load_err, 32'd0);

        // ADD 3+4
        host_write(4'd1, 16'h0003); host_write(4'd2, 16'h0004);
        do_instr(16'h0512, 0); probe(4'd1);
        // ADD overflow
        host_write(4'd1, 16'h7FFF); host_write(4'd2, 16'h0001);
        do_instr(16'h0512, 0); probe(4'd1);
        chk("ovf_flag_bit5", bus.flags[5], 32'd1);
        // CMP equal
        host_write(4'd1, 16'h0005); host_write(4'd2, 16'h0005);
        do_instr(16'h0B12, 0); probe(4'd1);
        chk("cmp_flags", bus.flags, 32'h40);
        // unsupported opcode
        do_instr(16'hEE12, 0); probe(4'd1);
        // host write rejected in EXEC, and concurrent with accept
        do_instr(16'h0112, 3); probe(4'd1);
        do_instr(16'h0222, 1); probe(4'd2);
        // A == B
        do_instr(16'h0533, 0); probe(4'd3);

        // reset while in EXEC
        bus.instr = 16'h0512; bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        chk("rst_exec_done", bus.done, 32'd0);
        chk("rst_exec_ready", bus.instr_ready, 32'd1);
        chk("rst_exec_flags", bus.flags, 32'd0);
        tick();
        chk("rst_exec_done2", bus.done, 32'd0);
        for (int i = 0; i < 16; i++) probe(i[3:0]);

        // randomized traffic
        for (int n = 0; n < 80; n++) begin
            rv = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                host_write(rv[3:0], $urandom);
            end else begin
                rv[15:8] = ($urandom_range(0, 9) == 0) ? rv[15:8] : op_list[$urandom_range(0, 13)];
                do_instr(rv, $urandom_range(0, 4));
            end
        end
        for (int i = 0; i < 16; i++) probe(i[3:0]);

`ifdef ALU_SEQ_DBG_EN
        dbg_addr = 4'd5;
        tick(); tick();
        chk("dbg_data", dbg_data, {16'd0, m_regs[5]});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Initiator-side controller for the 16-bit combinational ALU. Accepts one instruction word at a time over a valid/ready handshake, reads two operands from an internal 16x16 register file, drives the ALU's operand and opcode inputs, captures the result and flags, and writes back. Sits between the instruction fetch path and the ALU in the CPU datapath.

## Interface
Parameters:
- none. Widths are fixed: 16-bit data, 16 registers, 8-bit opcode.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  16  instruction: [15:8] ALU opcode, [7:4] register A, [3:0] register B.
- instr_valid  in  1  instr is presented.
- instr_ready  out  1  sequencer can accept instr.
- alu_r1  out  16  to ALU r1; registered.
- alu_r2  out  16  to ALU r2; registered.
- alu_opcode  out  8  to ALU opcode; registered.
- alu_rout  in  16  ALU result.
- alu_flags  in  8  ALU flags: C=bit0, L=bit2, F=bit5, Z=bit6, N=bit7.
- flags  out  8  architectural flag register.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  one-cycle pulse when an unsupported opcode retires.
- host_we  in  1  host register write request.
- host_addr  in  4  host write address.
- host_data  in  16  host write data.
- load_err  out  1  one-cycle pulse when host_we is rejected.
- dbg_addr  in  4  debug read address (ALU_SEQ_DBG_EN only).
- dbg_data  out  16  debug read data (ALU_SEQ_DBG_EN only).

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE: instr_ready=1. On instr_valid && instr_ready, latch instr and go to READ. Otherwise stay in IDLE.
- READ: alu_r1 <= R[A], alu_r2 <= R[B], alu_opcode <= instr[15:8]. Go to EXEC.
- EXEC: ALU output settles. Capture alu_rout and alu_flags into internal holding registers. Go to WRITE.
- WRITE: apply the result per the opcode class below, pulse done, return to IDLE.
- Opcode classes:
  - Write result to R[A], flags unchanged: 01, 02, 03, 04, 06, 07, 08, 0C, 0F, 84.
  - Write result to R[A] and load flags from alu_flags: 05 (ADD), 09 (SUB).
  - No register write, load flags only: 0B (CMP).
  - Any other opcode: no write and no flag change. err pulses together with done.
- A == B is legal. Both operands then read the same register value.
- Host writes: accepted only in IDLE when instr_valid is low, and write R[host_addr] on that edge. If instr_valid is also high in IDLE, the instruction is accepted and the host write is rejected. A rejected host write pulses load_err the next cycle.
- Reset:
  - Every output resets to 0, except instr_ready, which resets to 1.
  - All 16 registers and the flag register clear to 0.
  - State goes to IDLE.
- Reset mid-instruction abandons the instruction: no writeback, no done.

## Timing
- Accept edge T. Operands valid on the ALU inputs from T+1. Result captured at T+2. Register and flag update plus done at T+3. instr_ready=1 again at T+4.
- Throughput: one instruction per 4 cycles. instr_ready=0 in READ, EXEC and WRITE.
- alu_r1, alu_r2 and alu_opcode hold their values until the next READ.
- Register file writes take effect at the WRITE edge. A following instruction reads the updated value.

## Configuration
- ALU_SEQ_DBG_EN defined: the dbg_addr and dbg_data ports exist. dbg_data = R[dbg_addr] registered, one cycle latency, and reflects writes completed on earlier edges.
- ALU_SEQ_DBG_EN undefined: both ports are absent. All other behaviour is identical.

## Test plan
- Host writes R1=0x0003, R2=0x0004, then instr 0x0512 with a behavioural ALU model.
  - R1=0x0007, flags=0x00.
  - done pulses exactly 3 cycles after accept.
- R1=0x7FFF, R2=0x0001, instr 0x0512.
  - R1=0x8000, flags bit5=1.
- R1=R2=0x0005, instr 0x0B12.
  - flags=0x40, R1 unchanged at 0x0005, done pulses.
- Opcode 0xEE, instr 0xEE12.
  - err and done pulse together, no register or flag change, back to IDLE.
- host_we asserted during EXEC.
  - load_err pulses, target register unchanged.
- reset asserted in EXEC.
  - No done, all registers 0, instr_ready=1 in the first cycle after reset deasserts.
